// File: rtl/sprite_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_renderer
// Description : Per-scanline sprite rasteriser. Walks the secondary sprite list
//               for the current line. For each entry it reads the OAM word and
//               the matching sprite row from VRAM. It then composites the
//               opaque pixels into a line buffer, applying flip, clipping and
//               front-to-back priority.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               start_i             1-cycle pulse, render line_number_i
//               busy_o, done_o      activity flag, 1-cycle completion pulse
//               line_number_i       line being rendered (stable while busy)
//               second_array_i      packed list, entry k = {oam index, valid}
//               oam_re_o/oam_a_o    OAM read port, oam_d_i valid next cycle
//               vram_re_o/vram_a_o  VRAM read port, vram_d_i valid next cycle
//               line_buffer_o       rendered pixels, pixel p at [p*PW +: PW]
//               prio_buffer_o       priority bit of the winning sprite
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_renderer #(
   parameter int SPRITE_SIZE       = 16,
   parameter int PIXEL_WIDTH       = 8,
   parameter int TRANSPARENT       = 0,
   parameter int OAM_ADDR_SIZE     = 8,
   parameter int OAM_DATA_SIZE     = 32,
   parameter int VRAM_ADDR_SIZE    = 8 + $clog2(SPRITE_SIZE),
   parameter int VRAM_DATA_SIZE    = SPRITE_SIZE * PIXEL_WIDTH,
   parameter int SECOND_ARRAY_SIZE = 32,
   parameter int DISPLAY_WIDTH     = 640,
   parameter int LINE_NUMBER_WIDTH = 10
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             start_i,
   output logic                                             busy_o,
   output logic                                             done_o,
   input  logic [LINE_NUMBER_WIDTH-1:0]                     line_number_i,
   input  logic [SECOND_ARRAY_SIZE*(OAM_ADDR_SIZE+1)-1:0]   second_array_i,
   output logic                                             oam_re_o,
   output logic [OAM_ADDR_SIZE-1:0]                         oam_a_o,
   input  logic [OAM_DATA_SIZE-1:0]                         oam_d_i,
   output logic                                             vram_re_o,
   output logic [VRAM_ADDR_SIZE-1:0]                        vram_a_o,
   input  logic [VRAM_DATA_SIZE-1:0]                        vram_d_i,
   output logic [DISPLAY_WIDTH*PIXEL_WIDTH-1:0]             line_buffer_o,
   output logic [DISPLAY_WIDTH-1:0]                         prio_buffer_o
);

   localparam int c_ROW_W     = $clog2(SPRITE_SIZE);
   localparam int c_IDX_W     = $clog2(SECOND_ARRAY_SIZE + 1);
   localparam int c_ENT_W     = OAM_ADDR_SIZE + 1;
   localparam int c_X_W       = 11;
   localparam int c_BUF_IDX_W = $clog2(DISPLAY_WIDTH);
   localparam int c_DIFF_W    = LINE_NUMBER_WIDTH + 1;
   localparam logic [PIXEL_WIDTH-1:0] c_TRANSP = PIXEL_WIDTH'(TRANSPARENT);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_CLEAR   = 3'd1;
   localparam logic [2:0] c_OAM_RD  = 3'd2;
   localparam logic [2:0] c_OAM_LAT = 3'd3;
   localparam logic [2:0] c_VRAM_RD = 3'd4;
   localparam logic [2:0] c_DRAW    = 3'd5;
   localparam logic [2:0] c_DONE    = 3'd6;

   logic [2:0]                           state_q, state_d;
   logic [c_IDX_W-1:0]                   index_q, index_d;
   logic [7:0]                           ref_q;
   logic [9:0]                           x_q;
   logic                                 prio_q, xflip_q;
   logic [c_ROW_W-1:0]                   row_q;
   logic [DISPLAY_WIDTH*PIXEL_WIDTH-1:0] line_q;
   logic [DISPLAY_WIDTH-1:0]             prio_buf_q;
   logic [DISPLAY_WIDTH-1:0]             owned_q;

   // Current secondary-list entry; an index past the end reads as invalid.
   logic [c_ENT_W-1:0] w_entry;
   logic               w_list_end;
   always_comb begin
      w_entry = '0;
      for (int k = 0; k < SECOND_ARRAY_SIZE; k++)
         if (int'(index_q) == k) w_entry = second_array_i[k*c_ENT_W +: c_ENT_W];
   end
   assign w_list_end = (int'(index_q) >= SECOND_ARRAY_SIZE) || !w_entry[0];

   // OAM word fields, decoded in OAM_LAT while oam_d_i holds the read data.
   logic [9:0]          w_oam_y;
   logic [c_DIFF_W-1:0] w_diff;
   logic [c_ROW_W-1:0]  w_row;
   logic                w_visible;
   assign w_oam_y   = oam_d_i[27:18];
   // One extra bit so that line < y cannot alias into a small positive diff.
   assign w_diff    = c_DIFF_W'(line_number_i) - c_DIFF_W'(w_oam_y);
   assign w_visible = oam_d_i[31] &&
                      (c_DIFF_W'(line_number_i) >= c_DIFF_W'(w_oam_y)) &&
                      (w_diff < c_DIFF_W'(SPRITE_SIZE));
   assign w_row     = oam_d_i[30] ? (c_ROW_W'(SPRITE_SIZE - 1) - w_diff[c_ROW_W-1:0])
                                  : w_diff[c_ROW_W-1:0];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_IDLE;
         index_q <= '0;
         ref_q   <= '0;
         x_q     <= '0;
         prio_q  <= 1'b0;
         xflip_q <= 1'b0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         if (state_q == c_OAM_LAT) begin
            ref_q   <= oam_d_i[7:0];
            x_q     <= oam_d_i[17:8];
            prio_q  <= oam_d_i[28];
            xflip_q <= oam_d_i[29];
            row_q   <= w_row;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      case (state_q)
         c_IDLE:    if (start_i) state_d = c_CLEAR;
         c_CLEAR: begin
            index_d = '0;
            state_d = c_OAM_RD;
         end
         c_OAM_RD:  state_d = w_list_end ? c_DONE : c_OAM_LAT;
         c_OAM_LAT: begin
            if (w_visible) begin
               state_d = c_VRAM_RD;
            end else begin
               index_d = index_q + c_IDX_W'(1);
               state_d = c_OAM_RD;
            end
         end
         c_VRAM_RD: state_d = c_DRAW;
         c_DRAW: begin
            index_d = index_q + c_IDX_W'(1);
            state_d = c_OAM_RD;
         end
         c_DONE:    state_d = c_IDLE;
         default:   state_d = c_IDLE;
      endcase
   end

   // Output logic; address buses idle at zero when not strobed.
   always_comb begin
      busy_o    = (state_q != c_IDLE);
      done_o    = (state_q == c_DONE);
      oam_re_o  = 1'b0;
      oam_a_o   = '0;
      vram_re_o = 1'b0;
      vram_a_o  = '0;
      if (state_q == c_OAM_RD && !w_list_end) begin
         oam_re_o = 1'b1;
         oam_a_o  = w_entry[OAM_ADDR_SIZE:1];
      end
      if (state_q == c_VRAM_RD) begin
         vram_re_o = 1'b1;
         vram_a_o  = VRAM_ADDR_SIZE'({ref_q, row_q});
      end
   end

   // Per-pixel write enables for the row being drawn. A pixel already owned by
   // an earlier (front) sprite is never overwritten.
   logic [c_X_W-1:0]       w_x_pos [SPRITE_SIZE];
   logic [PIXEL_WIDTH-1:0] w_pix   [SPRITE_SIZE];
   logic [SPRITE_SIZE-1:0] w_we;
   always_comb begin
      for (int i = 0; i < SPRITE_SIZE; i++) begin
         w_x_pos[i] = c_X_W'(x_q) + c_X_W'(i);
         w_pix[i]   = xflip_q ? vram_d_i[(SPRITE_SIZE-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH]
                              : vram_d_i[i*PIXEL_WIDTH +: PIXEL_WIDTH];
         w_we[i]    = (state_q == c_DRAW) &&
                      (w_x_pos[i] < c_X_W'(DISPLAY_WIDTH)) &&
                      (w_pix[i] != c_TRANSP) &&
                      !owned_q[w_x_pos[i][c_BUF_IDX_W-1:0]];
      end
   end

   // Line, priority and ownership buffers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q     <= {DISPLAY_WIDTH{c_TRANSP}};
         prio_buf_q <= '0;
         owned_q    <= '0;
      end else if (state_q == c_CLEAR) begin
         line_q     <= {DISPLAY_WIDTH{c_TRANSP}};
         prio_buf_q <= '0;
         owned_q    <= '0;
      end else begin
         for (int i = 0; i < SPRITE_SIZE; i++) begin
            if (w_we[i]) begin
               line_q[int'(w_x_pos[i][c_BUF_IDX_W-1:0])*PIXEL_WIDTH +: PIXEL_WIDTH] <= w_pix[i];
               prio_buf_q[w_x_pos[i][c_BUF_IDX_W-1:0]] <= prio_q;
               owned_q[w_x_pos[i][c_BUF_IDX_W-1:0]]    <= 1'b1;
            end
         end
      end
   end

   assign line_buffer_o = line_q;
   assign prio_buffer_o = prio_buf_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sprite_line_renderer
// Description : Directed bench for sprite_line_renderer with OAM/VRAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_renderer;

   localparam int PW  = 8;
   localparam int SAS = 32;
   localparam int DW  = 640;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                busy, done;
   logic [9:0]          line_number;
   logic [SAS*9-1:0]    sa;
   logic                oam_re, vram_re;
   logic [7:0]          oam_a;
   logic [11:0]         vram_a;
   logic [31:0]         oam_d = '0;
   logic [127:0]        vram_d = '0;
   logic [DW*PW-1:0]    line_buffer;
   logic [DW-1:0]       prio_buffer;

   logic [31:0]  oam_mem  [256];
   logic [127:0] vram_mem [4096];

   int n_tests = 0;
   int n_fail  = 0;
   int exp_line [DW];
   int exp_prio [DW];
   int vre_cnt;
   logic [11:0] last_va;

   always #5 clk = ~clk;

   sprite_line_renderer dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .busy_o         (busy),
      .done_o         (done),
      .line_number_i  (line_number),
      .second_array_i (sa),
      .oam_re_o       (oam_re),
      .oam_a_o        (oam_a),
      .oam_d_i        (oam_d),
      .vram_re_o      (vram_re),
      .vram_a_o       (vram_a),
      .vram_d_i       (vram_d),
      .line_buffer_o  (line_buffer),
      .prio_buffer_o  (prio_buffer)
   );

   // Synchronous memories with one-cycle read latency
   always @(posedge clk) begin
      if (oam_re)  oam_d  <= oam_mem[oam_a];
      if (vram_re) vram_d <= vram_mem[vram_a];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oam_word(input int rf, input int x, input int y,
                                            input bit pr, input bit xf, input bit yf, input bit en);
      logic [31:0] w;
      w = {en, yf, xf, pr, 10'(y), 10'(x), 8'(rf)};
      return w;
   endfunction

   function automatic logic [127:0] row_seq();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(i + 1);
      return r;
   endfunction

   function automatic logic [127:0] row_const(input int v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(v);
      return r;
   endfunction

   task automatic clear_sa();
      sa = '0;
   endtask

   task automatic set_sa(input int k, input int addr);
      sa[k*9 +: 9] = {8'(addr), 1'b1};
   endtask

   task automatic clear_exp();
      for (int p = 0; p < DW; p++) begin
         exp_line[p] = 0;
         exp_prio[p] = 0;
      end
   endtask

   task automatic check_bufs(input string tag);
      for (int p = 0; p < DW; p++) begin
         check($sformatf("%s_pix%0d", tag, p), 32'(line_buffer[p*PW +: PW]), 32'(exp_line[p]));
         check($sformatf("%s_prio%0d", tag, p), 32'(prio_buffer[p]), 32'(exp_prio[p]));
      end
   endtask

   // Pulses start, counts cycles to done, optionally re-pulses start while busy.
   task automatic run_line(input string tag, input int exp_cycles, input int glitch_at);
      int cyc;
      bit seen;
      vre_cnt = 0;
      last_va = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      check({tag, "_busy1"}, 32'(busy), 32'd1);
      while (cyc <= 300) begin
         if (vram_re) begin
            vre_cnt++;
            last_va = vram_a;
         end
         start = (cyc == glitch_at);
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic setup_s1();
      clear_sa();
      set_sa(0, 0);
      oam_mem[0]       = oam_word(3, 100, 50, 0, 0, 0, 1);
      vram_mem[12'h035] = row_seq();
   endtask

   initial begin
      int cyc;
      bit seen;
      rst = 1'b1;
      start = 1'b0;
      line_number = 10'd55;
      sa = '0;
      for (int a = 0; a < 256; a++)  oam_mem[a]  = '0;
      for (int a = 0; a < 4096; a++) vram_mem[a] = '0;

      // Reset state
      #12;
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_oam_re",  32'(oam_re),  32'd0);
      check("rst_vram_re", 32'(vram_re), 32'd0);
      check("rst_oam_a",   32'(oam_a),   32'd0);
      check("rst_vram_a",  32'(vram_a),  32'd0);
      clear_exp();
      check_bufs("rst");
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // Single sprite, pixels 1..16 at x=100
      setup_s1();
      run_line("s1", 7, 0);
      check("s1_vram_a", 32'(last_va), 32'h035);
      check("s1_vram_reads", 32'(vre_cnt), 32'd1);
      clear_exp();
      for (int i = 0; i < 16; i++) exp_line[100 + i] = i + 1;
      check_bufs("s1");

      // Same sprite, x- and y-flipped: row 10, pixels reversed
      oam_mem[0]        = oam_word(3, 100, 50, 0, 1, 1, 1);
      vram_mem[12'h03A] = row_seq();
      run_line("s2", 7, 0);
      check("s2_vram_a", 32'(last_va), 32'h03A);
      clear_exp();
      for (int i = 0; i < 16; i++) exp_line[100 + i] = 16 - i;
      check_bufs("s2");

      // Overlap: front sprite has a transparent pixel 0
      clear_sa();
      set_sa(0, 1);
      set_sa(1, 2);
      oam_mem[1]        = oam_word(4, 10, 50, 0, 0, 0, 1);
      oam_mem[2]        = oam_word(5, 10, 50, 1, 0, 0, 1);
      vram_mem[12'h045] = row_const(5);
      vram_mem[12'h045][7:0] = 8'd0;
      vram_mem[12'h055] = row_const(9);
      run_line("s3", 11, 0);
      clear_exp();
      exp_line[10] = 9;
      exp_prio[10] = 1;
      for (int i = 11; i < 26; i++) exp_line[i] = 5;
      check_bufs("s3");

      // Right-edge clip plus a sprite fully off-screen at x=1000
      clear_sa();
      set_sa(0, 3);
      set_sa(1, 4);
      oam_mem[3]        = oam_word(6, 630, 50, 0, 0, 0, 1);
      oam_mem[4]        = oam_word(6, 1000, 50, 1, 0, 0, 1);
      vram_mem[12'h065] = row_const(7);
      run_line("s4", 11, 0);
      clear_exp();
      for (int i = 630; i < 640; i++) exp_line[i] = 7;
      check_bufs("s4");

      // Skips: disabled, wrong line, then invalid entry
      clear_sa();
      set_sa(0, 5);
      set_sa(1, 6);
      oam_mem[5] = oam_word(6, 50, 50, 0, 0, 0, 0);
      oam_mem[6] = oam_word(6, 50, 60, 0, 0, 0, 1);
      run_line("s5", 7, 0);
      check("s5_vram_reads", 32'(vre_cnt), 32'd0);
      clear_exp();
      check_bufs("s5");

      // Full list of 32 visible sprites, spurious start while busy
      clear_sa();
      for (int k = 0; k < SAS; k++) begin
         set_sa(k, 32 + k);
         oam_mem[32 + k] = oam_word(7, 20 * k, 55, 0, 0, 0, 1);
      end
      vram_mem[12'h070] = row_const(3);
      run_line("s6", 131, 10);
      check("s6_vram_reads", 32'(vre_cnt), 32'd32);
      clear_exp();
      for (int k = 0; k < SAS; k++)
         for (int i = 0; i < 16; i++) exp_line[20 * k + i] = 3;
      check_bufs("s6");
      repeat (3) @(negedge clk);
      check("s6_idle_no_restart", 32'(busy), 32'd0);

      // Reset mid-line
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",    32'(busy),    32'd0);
      check("mid_rst_oam_re",  32'(oam_re),  32'd0);
      check("mid_rst_vram_re", 32'(vram_re), 32'd0);
      clear_exp();
      check_bufs("mid_rst");
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);

      // Recovery after reset
      setup_s1();
      run_line("s7", 7, 0);
      clear_exp();
      for (int i = 0; i < 16; i++) exp_line[100 + i] = i + 1;
      check_bufs("s7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
